// File: rtl/btn_conditioner.sv
// Button/switch input stage: 2-flop synchronisers, per-button debounce with press strobe,
// and a switch snapshot on every strobe. Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module btn_conditioner #(
    parameter int                 NUM_BTN         = 5,
    parameter int                 SW_W            = 16,
    parameter int                 DEBOUNCE_CYCLES = 1000000,
    parameter int                 HOLD_CYCLES     = 50000000,
    parameter int                 REPEAT_CYCLES   = 10000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [SW_W-1:0]    sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [SW_W-1:0]    sw_latched,
    output logic [SW_W-1:0]    sw_sync
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_BTN-1:0]            r_btn_s1, r_btn_s2;
    logic [SW_W-1:0]               r_sw_s1, r_sw_s2;
    logic [NUM_BTN-1:0]            r_level, r_pulse;
    logic [SW_W-1:0]               r_sw_latched;
    logic [NUM_BTN-1:0][CNT_W-1:0] r_cnt;

    logic [NUM_BTN-1:0] w_toggle, w_press, w_release, w_repeat, w_pulse_next;

    // NOTE: every flop uses <= so all stages sample pre-edge values and the pipeline shifts by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_toggle[i] = (r_btn_s2[i] != r_level[i]) &&
                          (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    assign w_press      = w_toggle & ~r_level;
    assign w_release    = w_toggle & r_level;
    assign w_pulse_next = w_press | w_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                // Any sample that agrees with the current level restarts the stability count.
                if (r_btn_s2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_toggle[i]) begin
                    r_level[i] <= ~r_level[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse      <= '0;
            r_sw_latched <= '0;
        end else begin
            r_pulse <= w_pulse_next;
            if (|w_pulse_next) begin
                r_sw_latched <= r_sw_s2;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    // r_hold_cnt holds the number of edges since the last pulse of this button.
    logic [NUM_BTN-1:0][HOLD_W-1:0] r_hold_cnt;
    logic [NUM_BTN-1:0]             r_repeating;

    always_comb begin
        w_repeat = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (REPEAT_MASK[i] && r_level[i] && !w_release[i]) begin
                w_repeat[i] = r_repeating[i] ? (r_hold_cnt[i] == HOLD_W'(REPEAT_CYCLES))
                                             : (r_hold_cnt[i] == HOLD_W'(HOLD_CYCLES));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt  <= '0;
            r_repeating <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (REPEAT_MASK[i] && w_press[i]) begin
                    r_hold_cnt[i]  <= HOLD_W'(1);
                    r_repeating[i] <= 1'b0;
                end else if (!REPEAT_MASK[i] || !r_level[i] || w_release[i]) begin
                    r_hold_cnt[i]  <= '0;
                    r_repeating[i] <= 1'b0;
                end else if (w_repeat[i]) begin
                    r_hold_cnt[i]  <= HOLD_W'(1);
                    r_repeating[i] <= 1'b1;
                end else begin
                    r_hold_cnt[i] <= r_hold_cnt[i] + HOLD_W'(1);
                end
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_repeat     = '0;
    assign w_unused_cfg = ^{REPEAT_MASK, HOLD_CYCLES, REPEAT_CYCLES};
`endif

    assign btn_level  = r_level;
    assign btn_pulse  = r_pulse;
    assign sw_latched = r_sw_latched;
    assign sw_sync    = r_sw_s2;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: hand-derived vector table, directed corner sequences and
// randomized stimulus compared every cycle against a sliding-window reference model.
module tb_btn_conditioner;

    localparam int                 NUM_BTN = 5;
    localparam int                 SW_W    = 16;
    localparam int                 DEB     = 4;
    localparam int                 HOLD    = 20;
    localparam int                 REP     = 8;
    localparam logic [NUM_BTN-1:0] MASK    = 5'b10000;
`ifdef BTN_AUTOREPEAT_EN
    localparam int EXP_HOLD_PULSES4 = 6;
`else
    localparam int EXP_HOLD_PULSES4 = 1;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_BTN-1:0] btn_raw;
    logic [SW_W-1:0]    sw_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [SW_W-1:0]    sw_latched;
    logic [SW_W-1:0]    sw_sync;

    btn_conditioner #(
        .NUM_BTN        (NUM_BTN),
        .SW_W           (SW_W),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .sw_latched(sw_latched),
        .sw_sync   (sw_sync)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NUM_BTN-1:0] btn;
        logic [SW_W-1:0]    sw;
        logic [NUM_BTN-1:0] exp_level;
        logic [NUM_BTN-1:0] exp_pulse;
        logic [SW_W-1:0]    exp_latched;
    } vec_t;

    vec_t vecs[28];

    // Reference model: level flips once the last DEB synchronised samples since reset all differ from it.
    logic [NUM_BTN-1:0] m_b1, m_b2;
    logic [SW_W-1:0]    m_s1, m_s2;
    logic [NUM_BTN-1:0] m_win[$];
    logic [NUM_BTN-1:0] m_level, m_pulse;
    logic [SW_W-1:0]    m_latched;
    bit                 m_valid = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    int                 m_edge = 0;
    int                 m_press[NUM_BTN];
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [NUM_BTN-1:0] s_pre;
        logic [SW_W-1:0]    sw_pre;
        logic [NUM_BTN-1:0] nxt;
        s_pre  = m_b2;
        sw_pre = m_s2;
`ifdef BTN_AUTOREPEAT_EN
        m_edge++;
`endif
        if (rst) begin
            m_b1 = '0; m_b2 = '0; m_s1 = '0; m_s2 = '0;
            m_level = '0; m_pulse = '0; m_latched = '0;
            m_win.delete();
            m_valid = 1'b1;
            return;
        end
        m_b2 = m_b1; m_b1 = btn_raw;
        m_s2 = m_s1; m_s1 = sw_raw;
        m_win.push_front(s_pre);
        if (m_win.size() > DEB) void'(m_win.pop_back());
        nxt     = m_level;
        m_pulse = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            bit all_diff;
            all_diff = (m_win.size() == DEB);
            for (int j = 0; j < m_win.size(); j++)
                if (m_win[j][i] == m_level[i]) all_diff = 1'b0;
            if (all_diff) begin
                nxt[i] = ~m_level[i];
                if (!m_level[i]) begin
                    m_pulse[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    m_press[i] = m_edge;
`endif
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            if (MASK[i] && m_level[i] && nxt[i]) begin
                int d;
                d = m_edge - m_press[i];
                if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) m_pulse[i] = 1'b1;
            end
`endif
        end
        m_level = nxt;
        if (|m_pulse) m_latched = sw_pre;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_valid)
            check("model", {btn_level, btn_pulse, sw_latched, sw_sync},
                           {m_level, m_pulse, m_latched, m_s2});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_pulse(input string name, input logic [NUM_BTN-1:0] mask, input int max_cycles);
        bit seen = 1'b0;
        for (int k = 0; k < max_cycles && !seen; k++) begin
            tick();
            if ((btn_pulse & mask) != '0) seen = 1'b1;
        end
        check(name, seen, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, c_early, c_late, c0, c4;

        // Clean press on btnd: sampled at edge 1, accepted at edge 6; released at edge 20, level falls at 25.
        for (int k = 0; k < 28; k++) begin
            e = k + 1;
            vecs[k].btn         = (e <= 19) ? 5'b10000 : 5'b00000;
            vecs[k].sw          = 16'h00A5;
            vecs[k].exp_level   = (e >= 6 && e <= 24) ? 5'b10000 : 5'b00000;
            vecs[k].exp_pulse   = (e == 6) ? 5'b10000 : 5'b00000;
            vecs[k].exp_latched = (e >= 6) ? 16'h00A5 : 16'h0000;
        end

        rst = 1'b1; btn_raw = '0; sw_raw = 16'h00A5;
        tick();
        check("reset_state", {btn_level, btn_pulse, sw_latched, sw_sync}, 64'd0);
        idle(2);
        rst = 1'b0;
        idle(3);
        check("sw_sync_idle", sw_sync, 16'h00A5);

        foreach (vecs[k]) begin
            btn_raw = vecs[k].btn;
            sw_raw  = vecs[k].sw;
            tick();
            check("vec_level", btn_level, vecs[k].exp_level);
            check("vec_pulse", btn_pulse, vecs[k].exp_pulse);
            check("vec_latched", sw_latched, vecs[k].exp_latched);
        end

        // Bounce on btnc: 3 high / 1 low five times, then held high.
        c_early = 0; c_late = 0;
        for (int r = 0; r < 5; r++) begin
            btn_raw = 5'b00001;
            for (int k = 0; k < 3; k++) begin tick(); if (btn_pulse[0]) c_early++; end
            btn_raw = 5'b00000;
            tick(); if (btn_pulse[0]) c_early++;
        end
        btn_raw = 5'b00001;
        for (int k = 0; k < 5; k++) begin tick(); if (btn_pulse[0]) c_early++; end
        for (int k = 0; k < 10; k++) begin tick(); if (btn_pulse[0]) c_late++; end
        check("bounce_no_early_pulse", c_early, 0);
        check("bounce_single_pulse", c_late, 1);
        check("bounce_level", btn_level, 5'b00001);
        btn_raw = '0;
        idle(8);

        // Switch capture on btnl, then hold across a switch change, then a fresh capture.
        sw_raw = 16'hFFF6;
        idle(3);
        btn_raw = 5'b00010;
        wait_pulse("cap_pulse_seen", 5'b00010, 12);
        check("cap_latched", sw_latched, 16'hFFF6);
        sw_raw = 16'h0003;
        idle(6);
        check("cap_hold", sw_latched, 16'hFFF6);
        check("cap_sw_sync", sw_sync, 16'h0003);
        btn_raw = '0;
        idle(8);
        btn_raw = 5'b00010;
        wait_pulse("cap2_pulse_seen", 5'b00010, 12);
        check("cap2_latched", sw_latched, 16'h0003);
        btn_raw = '0;
        idle(8);

        // Simultaneous btnc + btnr.
        btn_raw = 5'b01001;
        wait_pulse("simul_pulse_seen", 5'b01001, 12);
        check("simul_pulse", btn_pulse, 5'b01001);
        tick();
        check("simul_one_cycle", btn_pulse, 5'b00000);
        btn_raw = '0;
        idle(8);

        // Reset after btnu has three stable synchronised cycles.
        btn_raw = 5'b00100;
        idle(5);
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", {btn_level, btn_pulse, sw_latched, sw_sync}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_repress_wait", btn_level[2], 1'b0);
        end
        tick();
        check("rst_repress_level", btn_level, 5'b00100);
        check("rst_repress_pulse", btn_pulse, 5'b00100);
        btn_raw = '0;
        idle(8);

        // Long hold on btnd (repeat-enabled) and btnc (not enabled).
        c0 = 0; c4 = 0;
        btn_raw = 5'b10001;
        for (int k = 0; k < 59; k++) begin tick(); c0 += int'(btn_pulse[0]); c4 += int'(btn_pulse[4]); end
        btn_raw = '0;
        for (int k = 0; k < 10; k++) begin tick(); c0 += int'(btn_pulse[0]); c4 += int'(btn_pulse[4]); end
        check("hold_btn0_pulses", c0, 1);
        check("hold_btn4_pulses", c4, EXP_HOLD_PULSES4);

        // Randomized: sparse button flips with random hold lengths, random switches, rare resets.
        for (int seg = 0; seg < 300; seg++) begin
            rst     = ($urandom_range(0, 39) == 0);
            btn_raw = btn_raw ^ (5'($urandom) & 5'($urandom));
            sw_raw  = 16'($urandom);
            if (rst) tick();
            else idle($urandom_range(1, 10));
            rst = 1'b0;
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the calculator top; sits between the board pins (push buttons, slide switches) and the decoder/accumulator logic.
- Synchronises and debounces each button and emits a clean level plus a single-cycle press pulse in the clk domain.
- Captures a synchronised switch snapshot on each press pulse, so the accumulator updates on a clk-domain strobe rather than on a raw button edge.

Parameters:
- NUM_BTN, 5, number of buttons; bit order 0=btnc, 1=btnl, 2=btnu, 3=btnr, 4=btnd.
- SW_W, 16, switch bus width.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); minimum 1.
- HOLD_CYCLES, 50000000, auto-repeat initial delay (used only with the optional feature).
- REPEAT_CYCLES, 10000000, auto-repeat period (used only with the optional feature).
- REPEAT_MASK, 5'b00000, per-button auto-repeat enable (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  NUM_BTN  asynchronous raw button inputs.
- sw_raw  input  SW_W  asynchronous raw switch inputs.
- btn_level  output  NUM_BTN  debounced button level.
- btn_pulse  output  NUM_BTN  one-cycle strobe on an accepted press.
- sw_latched  output  SW_W  switch snapshot taken at the most recent press pulse.
- sw_sync  output  SW_W  continuously synchronised switches (2-flop).

Behaviour:
- Reset (rst high at posedge):
  - btn_level=0, btn_pulse=0, sw_latched=0.
  - Synchroniser flops=0, debounce/repeat counters=0.
  - Takes effect mid-debounce or mid-hold; partial counts are discarded.
- Synchroniser: each btn_raw and sw_raw bit passes through 2 flops; s[i] is the second-flop output.
- Debounce, per button, independently:
  - State is btn_level[i]; counter cnt[i] is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - If s[i]==btn_level[i]: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: btn_level toggles, cnt<=0.
  - Else: cnt<=cnt+1.
  - cnt never wraps; it is cleared on every toggle.
- Latency: with btn_raw held, btn_level changes on the (2+DEBOUNCE_CYCLES)-th posedge after the first posedge that samples the new value.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES synchronised cycles resets cnt and produces no level change and no pulse. This applies to both press and release.
- btn_pulse[i]:
  - High for exactly one cycle, the same cycle btn_level[i] rises 0->1.
  - Never asserted on release.
  - Never two consecutive cycles (without the optional feature).
- Simultaneous presses: buttons are fully independent; several btn_pulse bits may assert in the same cycle.
- sw_latched:
  - Loads s_sw on the posedge where any btn_pulse bit goes high. The new value is visible in the same cycle the pulse is high; the value is the sw_sync sampled at that edge.
  - Otherwise holds.
- sw_sync = switch second-flop output, 2-cycle latency from sw_raw.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined, for each button with REPEAT_MASK[i]=1 while btn_level[i]=1:
  - A hold counter starts at the press pulse.
  - The first repeat pulse fires HOLD_CYCLES cycles after the press pulse.
  - Further pulses fire every REPEAT_CYCLES cycles after that.
  - Every repeat pulse is one cycle wide and also loads sw_latched.
  - Counters clear when btn_level falls or on rst.
  - Masked buttons behave exactly as in the undefined case.
- Undefined: no repeat counters are synthesised; one pulse per accepted press only.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, NUM_BTN=5, SW_W=16):
- Clean press: btn_raw[4] 0->1 held 20 cycles -> btn_level[4] rises on 6th posedge; btn_pulse[4] high exactly 1 cycle; no pulse on release after 6 more cycles.
- Bounce: btn_raw[0] toggled high 3 cycles / low 1 cycle, five times, then held high -> single pulse only; none during the bounce.
- Switch capture: sw_raw=16'hFFF6, press btn_raw[1] -> sw_latched=16'hFFF6 in the pulse cycle; changing sw_raw to 16'h0003 afterwards leaves sw_latched unchanged until the next pulse.
- Simultaneous: btn_raw[0] and btn_raw[3] rise on the same edge -> btn_pulse=5'b01001 in one cycle.
- Reset mid-debounce: rst high for 1 cycle while btn_raw[2] has been high 3 synced cycles -> all outputs 0; press then takes a full 4 more synced cycles to be accepted.
- BTN_AUTOREPEAT_EN with REPEAT_MASK=5'b10000: btn_raw[4] held 60 cycles -> pulses at press, +20, +28, +36, +44, ...; btn_raw[0] held identically -> exactly one pulse.
